// File: rtl/alu_driver.sv
// Multicycle ALU initiator: decodes an RV32I request, drives the ALU for one cycle, returns the result.
// Build option: define ALU_DRIVER_BRANCH_EN to accept conditional branches (opcode 1100011).
module alu_driver (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic        req_funct7_5,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_imm,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_taken,
  output logic        rsp_illegal,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and ready is only high in IDLE out of reset.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
`ifdef ALU_DRIVER_BRANCH_EN
  localparam logic [6:0] OP_B = 7'b1100011;
`endif

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SLL  = 4'b0101;
  localparam logic [3:0] C_SRL  = 4'b0110;
  localparam logic [3:0] C_SRA  = 4'b0111;
  localparam logic [3:0] C_SLT  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;
  localparam logic [3:0] C_ILL  = 4'b1111;

  logic [1:0]  state;
  logic [3:0]  dec_control;
  logic [31:0] dec_b;
  logic        dec_illegal;
  logic        illegal_q;
`ifdef ALU_DRIVER_BRANCH_EN
  logic        dec_branch;
  logic        dec_take_on_zero;
  logic        branch_q;
  logic        take_on_zero_q;
`endif

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

  always_comb begin
    dec_control = C_ILL;
    dec_b       = req_rs2;
    dec_illegal = 1'b1;
`ifdef ALU_DRIVER_BRANCH_EN
    dec_branch       = 1'b0;
    dec_take_on_zero = 1'b0;
`endif
    case (req_opcode)
      OP_R, OP_I: begin
        dec_illegal = 1'b0;
        dec_b       = (req_opcode == OP_I) ? req_imm : req_rs2;
        case (req_funct3)
          3'b000:  dec_control = (req_funct7_5 && req_opcode == OP_R) ? C_SUB : C_ADD;
          3'b001:  dec_control = C_SLL;
          3'b010:  dec_control = C_SLT;
          3'b011:  dec_control = C_SLTU;
          3'b100:  dec_control = C_XOR;
          3'b101:  dec_control = req_funct7_5 ? C_SRA : C_SRL;
          3'b110:  dec_control = C_OR;
          default: dec_control = C_AND;
        endcase
      end
`ifdef ALU_DRIVER_BRANCH_EN
      // Every branch compare lands on the zero flag: SUB for equality, SLT/SLTU for ordering.
      OP_B: begin
        dec_b = req_rs2;
        if (req_funct3[2:1] != 2'b01) begin
          dec_illegal      = 1'b0;
          dec_branch       = 1'b1;
          dec_take_on_zero = req_funct3[2] ? req_funct3[0] : !req_funct3[0];
          case (req_funct3[2:1])
            2'b00:   dec_control = C_SUB;
            2'b10:   dec_control = C_SLT;
            default: dec_control = C_SLTU;
          endcase
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_control   <= 4'b0000;
      illegal_q     <= 1'b0;
      rsp_result    <= '0;
      rsp_zero      <= 1'b0;
      rsp_taken     <= 1'b0;
      rsp_illegal   <= 1'b0;
`ifdef ALU_DRIVER_BRANCH_EN
      branch_q       <= 1'b0;
      take_on_zero_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_operand_a <= req_rs1;
            alu_operand_b <= dec_b;
            alu_control   <= dec_control;
            illegal_q     <= dec_illegal;
`ifdef ALU_DRIVER_BRANCH_EN
            branch_q       <= dec_branch;
            take_on_zero_q <= dec_take_on_zero;
`endif
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result  <= illegal_q ? 32'd0 : alu_result;
          rsp_zero    <= illegal_q ? 1'b1 : alu_zero;
          rsp_illegal <= illegal_q;
`ifdef ALU_DRIVER_BRANCH_EN
          rsp_taken   <= branch_q && (take_on_zero_q ? alu_zero : !alu_zero);
`else
          rsp_taken   <= 1'b0;
`endif
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver: a behavioural ALU closes the loop, vectors carry hand-computed results.
module tb_alu_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic        req_funct7_5;
  logic [31:0] req_rs1, req_rs2, req_imm;
  logic [31:0] alu_operand_a, alu_operand_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_taken, rsp_illegal;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [6:0] OR_ = 7'b0110011;
  localparam logic [6:0] OI_ = 7'b0010011;
  localparam logic [6:0] OB_ = 7'b1100011;
  localparam logic [6:0] OL_ = 7'b0000011;

  always #5 clk = ~clk;

  alu_driver dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7_5(req_funct7_5),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_taken(rsp_taken),
    .rsp_illegal(rsp_illegal), .dbg_state(dbg_state)
  );

  // Reference ALU; undefined codes return a marker so forced-zero results are observable.
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_operand_a + alu_operand_b;
      4'b0001: alu_result = alu_operand_a - alu_operand_b;
      4'b0010: alu_result = alu_operand_a & alu_operand_b;
      4'b0011: alu_result = alu_operand_a | alu_operand_b;
      4'b0100: alu_result = alu_operand_a ^ alu_operand_b;
      4'b0101: alu_result = alu_operand_a << alu_operand_b[4:0];
      4'b0110: alu_result = alu_operand_a >> alu_operand_b[4:0];
      4'b0111: alu_result = $unsigned($signed(alu_operand_a) >>> alu_operand_b[4:0]);
      4'b1000: alu_result = {31'd0, $signed(alu_operand_a) < $signed(alu_operand_b)};
      4'b1001: alu_result = {31'd0, alu_operand_a < alu_operand_b};
      default: alu_result = 32'hDEADBEEF;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1, rs2, imm;
    logic [3:0]  ctrl;
    logic        chk_b;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero, taken, ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                     input logic [3:0] ctrl, input logic chk_b, input logic [31:0] b,
                     input logic [31:0] res, input logic zero, input logic taken, input logic ill);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.ctrl = ctrl; v.chk_b = chk_b; v.b = b; v.res = res; v.zero = zero; v.taken = taken; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic drive_req(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    req_valid = 1'b1; req_opcode = op; req_funct3 = f3; req_funct7_5 = f7;
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_vec(input vec_t v);
    check({v.name, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
    drive_req(v.op, v.f3, v.f7, v.rs1, v.rs2, v.imm);
    @(negedge clk);
    req_valid = 1'b0;
    check({v.name, " state exec"}, {30'd0, dbg_state}, {30'd0, S_EXEC});
    check({v.name, " rsp_valid T+1"}, {31'd0, rsp_valid}, 32'd0);
    check({v.name, " alu_control"}, {28'd0, alu_control}, {28'd0, v.ctrl});
    check({v.name, " operand_a"}, alu_operand_a, v.rs1);
    if (v.chk_b) check({v.name, " operand_b"}, alu_operand_b, v.b);
    @(negedge clk);
    check({v.name, " rsp_valid T+2"}, {31'd0, rsp_valid}, 32'd1);
    check({v.name, " req_ready resp"}, {31'd0, req_ready}, 32'd0);
    check({v.name, " rsp_result"}, rsp_result, v.res);
    check({v.name, " rsp_zero"}, {31'd0, rsp_zero}, {31'd0, v.zero});
    check({v.name, " rsp_taken"}, {31'd0, rsp_taken}, {31'd0, v.taken});
    check({v.name, " rsp_illegal"}, {31'd0, rsp_illegal}, {31'd0, v.ill});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({v.name, " rsp_valid drop"}, {31'd0, rsp_valid}, 32'd0);
    check({v.name, " control holds"}, {28'd0, alu_control}, {28'd0, v.ctrl});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = '0; req_funct3 = '0; req_funct7_5 = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_imm = '0;

    //   name     op   f3      f7  rs1           rs2           imm           ctrl     chk b             result        z  t  ill
    add("add",    OR_, 3'b000, 0, 32'd5,        32'd7,        32'd0,        4'b0000, 1, 32'd7,        32'd12,       0, 0, 0);
    add("srai",   OI_, 3'b101, 1, 32'h80000000, 32'd0,        32'h404,      4'b0111, 1, 32'h404,      32'hF8000000, 0, 0, 0);
    add("sub",    OR_, 3'b000, 1, 32'd20,       32'd5,        32'd0,        4'b0001, 1, 32'd5,        32'd15,       0, 0, 0);
    add("addi_n", OI_, 3'b000, 1, 32'd10,       32'd99,       32'hFFFFFFFF, 4'b0000, 1, 32'hFFFFFFFF, 32'd9,        0, 0, 0);
    add("slt",    OR_, 3'b010, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1000, 1, 32'd1,        32'd1,        0, 0, 0);
    add("sltu",   OR_, 3'b011, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1001, 1, 32'd1,        32'd0,        1, 0, 0);
    add("xor",    OR_, 3'b100, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        4'b0100, 1, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0);
    add("srl",    OR_, 3'b101, 0, 32'h80000000, 32'd4,        32'd0,        4'b0110, 1, 32'd4,        32'h08000000, 0, 0, 0);
    add("or",     OR_, 3'b110, 0, 32'h0F,       32'hF0,       32'd0,        4'b0011, 1, 32'hF0,       32'hFF,       0, 0, 0);
    add("andi",   OI_, 3'b111, 0, 32'h12345678, 32'd0,        32'h0000FFFF, 4'b0010, 1, 32'h0000FFFF, 32'h5678,     0, 0, 0);
    add("slli",   OI_, 3'b001, 0, 32'd1,        32'd0,        32'h1F,       4'b0101, 1, 32'h1F,       32'h80000000, 0, 0, 0);
    add("load",   OL_, 3'b010, 0, 32'd5,        32'd7,        32'd0,        4'b1111, 0, 32'd0,        32'd0,        1, 0, 1);
`ifdef ALU_DRIVER_BRANCH_EN
    add("blt",    OB_, 3'b100, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1000, 1, 32'd1,        32'd1,        0, 1, 0);
    add("bgeu",   OB_, 3'b111, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1001, 1, 32'd1,        32'd0,        1, 1, 0);
    add("beq",    OB_, 3'b000, 0, 32'd9,        32'd9,        32'd0,        4'b0001, 1, 32'd9,        32'd0,        1, 1, 0);
    add("bne_nt", OB_, 3'b001, 0, 32'd9,        32'd9,        32'd0,        4'b0001, 1, 32'd9,        32'd0,        1, 0, 0);
`else
    add("blt",    OB_, 3'b100, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1111, 0, 32'd0,        32'd0,        1, 0, 1);
    add("bgeu",   OB_, 3'b111, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1111, 0, 32'd0,        32'd0,        1, 0, 1);
    add("beq",    OB_, 3'b000, 0, 32'd9,        32'd9,        32'd0,        4'b1111, 0, 32'd0,        32'd0,        1, 0, 1);
`endif
    add("b010",   OB_, 3'b010, 0, 32'd9,        32'd9,        32'd0,        4'b1111, 0, 32'd0,        32'd0,        1, 0, 1);

    // Reset state
    @(negedge clk);
    check("rst req_ready", {31'd0, req_ready}, 32'd0);
    check("rst state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst operand_a", alu_operand_a, 32'd0);
    check("rst control", {28'd0, alu_control}, 32'd0);
    check("rst rsp_result", rsp_result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: SUB 9-9 held for 4 cycles, a competing request must be ignored.
    drive_req(OR_, 3'b000, 1'b1, 32'd9, 32'd9, 32'd0);
    @(negedge clk);
    drive_req(OR_, 3'b000, 1'b0, 32'd100, 32'd1, 32'd0);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      check("stall rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall rsp_result", rsp_result, 32'd0);
      check("stall rsp_zero", {31'd0, rsp_zero}, 32'd1);
      check("stall req_ready", {31'd0, req_ready}, 32'd0);
      check("stall operand_a", alu_operand_a, 32'd9);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("release state idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("release no accept", alu_operand_a, 32'd9);
    check("release req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("second accepted", alu_operand_a, 32'd100);
    check("second state exec", {30'd0, dbg_state}, {30'd0, S_EXEC});
    @(negedge clk);
    check("second result", rsp_result, 32'd101);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset in EXEC drops the request.
    drive_req(OR_, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("pre-rst exec", {30'd0, dbg_state}, {30'd0, S_EXEC});
    rst = 1'b1;
    #1;
    check("mid-rst state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("mid-rst operand_a", alu_operand_a, 32'd0);
    check("mid-rst operand_b", alu_operand_b, 32'd0);
    check("mid-rst control", {28'd0, alu_control}, 32'd0);
    check("mid-rst req_ready", {31'd0, req_ready}, 32'd0);
    check("mid-rst rsp_result", rsp_result, 32'd0);
    check("mid-rst rsp_zero", {31'd0, rsp_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("post-rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    begin
      vec_t v;
      v.name = "add_1_1"; v.op = OR_; v.f3 = 3'b000; v.f7 = 1'b0;
      v.rs1 = 32'd1; v.rs2 = 32'd1; v.imm = 32'd0; v.ctrl = 4'b0000; v.chk_b = 1'b1;
      v.b = 32'd1; v.res = 32'd2; v.zero = 1'b0; v.taken = 1'b0; v.ill = 1'b0;
      run_vec(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
